// File: rtl/shift_reg2_pkg.sv
// Shared constants and types for the shift_reg2 controller and its datapath register.
// Holds the direction codes, the command opcode enum and the controller FSM states.
package shift_reg2_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 3;

    localparam logic [2:0] DIR_SHR  = 3'b000;
    localparam logic [2:0] DIR_LOAD = 3'b011;
    localparam logic [2:0] DIR_ROL2 = 3'b100;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'b00,
        OP_SHR      = 2'b01,
        OP_ROL2     = 2'b10,
        OP_LOAD_SHR = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        SETTLE,
        RESP
    } state_t;

    // Only ROL2 rotates; every other stepping operation is a logical right shift.
    function automatic logic [2:0] step_dir(input op_t op);
        return (op == OP_ROL2) ? DIR_ROL2 : DIR_SHR;
    endfunction

endpackage

// File: rtl/shift_reg2_ctrl_if.sv
// Command and response handshake bundle between the control logic and shift_reg2_ctrl.
// The master side issues commands and consumes responses.
interface shift_reg2_ctrl_if
    import shift_reg2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_count;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_reg2.sv
// 8-bit datapath register driven by shift_reg2_ctrl: load, logical right shift, rotate left by 2.
// It has no reset of its own; its contents survive a controller reset.
module shift_reg2
    import shift_reg2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              enable,
    input  logic [2:0]        shift_direction,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (enable) begin
            case (shift_direction)
                DIR_SHR:  data_out <= {1'b0, data_out[DATA_W-1:1]};
                DIR_LOAD: data_out <= data_in;
                DIR_ROL2: data_out <= {data_out[DATA_W-3:0], data_out[DATA_W-1:DATA_W-2]};
                default:  data_out <= data_out;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg2_ctrl.sv
// Sequences shift_reg2 pins for one command at a time and returns the resulting register value.
// All outputs, including the shift-register pins, are registered.
module shift_reg2_ctrl
    import shift_reg2_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    shift_reg2_ctrl_if.slave  bus,
    output logic              sr_enable,
    output logic [2:0]        sr_shift_direction,
    output logic [DATA_W-1:0] sr_data_in,
    input  logic [DATA_W-1:0] sr_data_out
);

    state_t           state;
    op_t              op;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] step_cnt;

    // step_cnt holds the enable cycles still to run, including the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            op                 <= OP_LOAD;
            count              <= '0;
            step_cnt           <= '0;
            bus.cmd_ready      <= 1'b1;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_data       <= '0;
            sr_enable          <= 1'b0;
            sr_shift_direction <= DIR_SHR;
            sr_data_in         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op            <= op_t'(bus.cmd_op);
                        count         <= bus.cmd_count;
                        sr_data_in    <= bus.cmd_data;
                        bus.cmd_ready <= 1'b0;
                        if (op_t'(bus.cmd_op) == OP_LOAD || op_t'(bus.cmd_op) == OP_LOAD_SHR) begin
                            state              <= LOAD;
                            sr_enable          <= 1'b1;
                            sr_shift_direction <= DIR_LOAD;
                        end else if (bus.cmd_count != '0) begin
                            state              <= STEP;
                            step_cnt           <= bus.cmd_count;
                            sr_enable          <= 1'b1;
                            sr_shift_direction <= step_dir(op_t'(bus.cmd_op));
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end

                LOAD: begin
                    if (op == OP_LOAD_SHR && count != '0) begin
                        state              <= STEP;
                        step_cnt           <= count;
                        sr_shift_direction <= DIR_SHR;
                    end else begin
                        state              <= SETTLE;
                        sr_enable          <= 1'b0;
                        sr_shift_direction <= DIR_SHR;
                    end
                end

                STEP: begin
                    step_cnt <= step_cnt - CNT_W'(1);
                    if (step_cnt == CNT_W'(1)) begin
                        state              <= SETTLE;
                        sr_enable          <= 1'b0;
                        sr_shift_direction <= DIR_SHR;
                    end
                end

                // The last enabled edge has landed, so data_out is final here.
                SETTLE: begin
                    bus.rsp_data  <= sr_data_out;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg2_ctrl.sv
// Directed bench for shift_reg2_ctrl driving a real shift_reg2; expected values are hand-computed.
module tb_shift_reg2_ctrl;
    import shift_reg2_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sr_enable;
    logic [2:0] sr_shift_direction;
    logic [7:0] sr_data_in;
    logic [7:0] sr_data_out;

    int vectors = 0;
    int miscompares = 0;

    int         en_cycles;
    int         rsp_cycle;
    logic [2:0] dir_log [8];
    logic [7:0] load_data;
    int         rsp_seen;

    shift_reg2_ctrl_if #(.DATA_W(8), .CNT_W(3)) bus ();

    shift_reg2_ctrl #(.DATA_W(8), .CNT_W(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .sr_enable          (sr_enable),
        .sr_shift_direction (sr_shift_direction),
        .sr_data_in         (sr_data_in),
        .sr_data_out        (sr_data_out)
    );

    shift_reg2 #(.DATA_W(8)) sreg (
        .clk             (clk),
        .enable          (sr_enable),
        .shift_direction (sr_shift_direction),
        .data_in         (sr_data_in),
        .data_out        (sr_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a command from a negedge; returns just after the acceptance edge.
    task automatic issue(input op_t op, input logic [2:0] cnt, input logic [7:0] data);
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Cycle k is the k-th negedge after acceptance; stops at the first rsp_valid.
    task automatic observe();
        en_cycles = 0;
        rsp_cycle = -1;
        load_data = 8'hxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sr_enable) begin
                if (en_cycles < 8) dir_log[en_cycles] = sr_shift_direction;
                if (sr_shift_direction == DIR_LOAD) load_data = sr_data_in;
                en_cycles++;
            end
            if (bus.rsp_valid) begin
                rsp_cycle = k;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input op_t op, input logic [2:0] cnt, input logic [7:0] data,
                          input int exp_en, input int exp_cycle, input logic [7:0] exp_data);
        issue(op, cnt, data);
        observe();
        check({name, ".enables"}, en_cycles, exp_en);
        check({name, ".latency"}, rsp_cycle, exp_cycle);
        check({name, ".rsp_data"}, bus.rsp_data, exp_data);
        check({name, ".cmd_ready_busy"}, bus.cmd_ready, 1'b0);
        release_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_count = 3'd0;
        bus.cmd_data  = 8'hFF;
        bus.rsp_ready = 1'b0;

        // Reset held with a command pending: reset wins.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.cmd_ready", bus.cmd_ready, 1'b1);
        check("rst.sr_enable", sr_enable, 1'b0);
        check("rst.direction", sr_shift_direction, 3'b000);
        check("rst.sr_data_in", sr_data_in, 8'h00);
        check("rst.rsp_valid", bus.rsp_valid, 1'b0);
        check("rst.rsp_data", bus.rsp_data, 8'h00);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_op("load_a5", OP_LOAD, 3'd0, 8'hA5, 1, 3, 8'hA5);
        check("load_a5.dir", dir_log[0], DIR_LOAD);
        check("load_a5.data_in", load_data, 8'hA5);

        run_op("ldshr_a5", OP_LOAD_SHR, 3'd3, 8'hA5, 4, 6, 8'h14);
        check("ldshr_a5.dir0", dir_log[0], DIR_LOAD);
        check("ldshr_a5.dir1", dir_log[1], DIR_SHR);
        check("ldshr_a5.dir3", dir_log[3], DIR_SHR);

        run_op("load_81a", OP_LOAD, 3'd0, 8'h81, 1, 3, 8'h81);
        run_op("rol2_x1", OP_ROL2, 3'd1, 8'h00, 1, 3, 8'h06);
        check("rol2_x1.dir", dir_log[0], DIR_ROL2);

        run_op("load_81b", OP_LOAD, 3'd0, 8'h81, 1, 3, 8'h81);
        run_op("rol2_x4", OP_ROL2, 3'd4, 8'h00, 4, 6, 8'h81);
        check("rol2_x4.dir3", dir_log[3], DIR_ROL2);

        run_op("load_3c", OP_LOAD, 3'd0, 8'h3C, 1, 3, 8'h3C);

        // SHR by zero, then hold the response while a new command waits.
        issue(OP_SHR, 3'd0, 8'h00);
        observe();
        check("shr0.enables", en_cycles, 0);
        check("shr0.latency", rsp_cycle, 2);
        bus.cmd_op    = OP_LOAD;
        bus.cmd_count = 3'd0;
        bus.cmd_data  = 8'h55;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold.rsp_valid", bus.rsp_valid, 1'b1);
            check("hold.rsp_data", bus.rsp_data, 8'h3C);
            check("hold.cmd_ready", bus.cmd_ready, 1'b0);
            check("hold.sr_enable", sr_enable, 1'b0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("turn.cmd_ready", bus.cmd_ready, 1'b1);
        check("turn.rsp_valid", bus.rsp_valid, 1'b0);
        check("turn.sr_enable", sr_enable, 1'b0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("next.sr_enable", sr_enable, 1'b1);
        check("next.dir", sr_shift_direction, DIR_LOAD);
        check("next.sr_data_in", sr_data_in, 8'h55);
        rsp_seen = 0;
        for (int k = 0; k < 10 && !bus.rsp_valid; k++) @(negedge clk);
        check("next.rsp_valid", bus.rsp_valid, 1'b1);
        check("next.rsp_data", bus.rsp_data, 8'h55);
        release_rsp();
        check("hold.sr_data_in", sr_data_in, 8'h55);

        // Reset during the second step of SHR x5: register keeps two shifts.
        issue(OP_SHR, 3'd5, 8'h00);
        @(negedge clk);
        check("abort.step1_en", sr_enable, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort.sr_enable", sr_enable, 1'b0);
        check("abort.cmd_ready", bus.cmd_ready, 1'b1);
        check("abort.rsp_valid", bus.rsp_valid, 1'b0);
        check("abort.reg", sr_data_out, 8'h15);
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        check("abort.no_rsp", rsp_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_reg2_ctrl.md
Name: shift_reg2_ctrl

Overview:
Command-side driver for the 8-bit shift_reg2 datapath register. It accepts one operation request over a valid/ready handshake and sequences the register's enable, shift_direction and data_in pins for the required number of cycles. It then captures the register's data_out and returns it over a valid/ready response channel. It sits between the control logic and the shift register and owns all shift-register pin activity.

Parameters:
DATA_W, 8, data width; must match shift register width (fixed at 8 for this revision)
CNT_W, 3, width of step count; max 7 steps per command

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 LOAD, 01 SHR, 10 ROL2, 11 LOAD_SHR
cmd_count  in  CNT_W  number of shift/rotate steps
cmd_data  in  DATA_W  parallel load value
sr_enable  out  1  to shift register enable
sr_shift_direction  out  3  to shift register shift_direction
sr_data_in  out  DATA_W  to shift register data_in
sr_data_out  in  DATA_W  from shift register data_out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  DATA_W  captured register value

Behaviour:
- Direction codes driven on sr_shift_direction:
  - DIR_SHR = 3'b000: logical right by 1, zero into MSB.
  - DIR_LOAD = 3'b011: parallel load of data_in.
  - DIR_ROL2 = 3'b100: rotate left by 2.
- Reset (sync): state IDLE, cmd_ready=1, sr_enable=0, sr_shift_direction=000, sr_data_in=0, rsp_valid=0, rsp_data=0, step counter=0.
- Outputs to the shift register are registered. sr_data_in holds the latched cmd_data from acceptance until the next acceptance.
- FSM states: IDLE, LOAD, STEP, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op/count/data.
  - Next state: LOAD for LOAD and LOAD_SHR. Otherwise STEP if count>0, else SETTLE.
- LOAD: exactly one cycle with sr_enable=1 and direction DIR_LOAD.
  - LOAD goes to SETTLE.
  - LOAD_SHR goes to STEP if count>0, else SETTLE.
- STEP:
  - sr_enable=1 for exactly count consecutive cycles.
  - Direction is DIR_SHR (SHR, LOAD_SHR) or DIR_ROL2 (ROL2).
  - Down-counter; go to SETTLE after the last step.
- SETTLE:
  - One cycle with sr_enable=0 and direction 000.
  - rsp_data <= sr_data_out at the end of this cycle; go to RESP.
- RESP:
  - rsp_valid=1 and rsp_data held stable until rsp_ready.
  - On rsp_ready, go to IDLE. The next command can be accepted in the following cycle (no same-cycle turnaround).
- cmd_ready=0 in every state except IDLE. cmd_valid is ignored outside IDLE.
- sr_enable is 0 in IDLE, SETTLE and RESP. The block never enables the register while a response is pending.
- Latency: with E = total enable cycles, rsp_valid is first high E+2 cycles after the acceptance edge.
  - LOAD: E=1, rsp_valid 3 cycles after acceptance.
  - SHR or ROL2 with count=0: E=0, rsp_valid 2 cycles after acceptance; returns the unchanged register value.
- Reset mid-operation: on the next edge all outputs return to reset values and sr_enable drops immediately. The shift register's partial contents are not restored. A pending response is discarded.
- Simultaneous reset and cmd_valid: reset wins and the command is not accepted.

Decomposition:
- Package shift_reg2_pkg, holding:
  - DIR_SHR/DIR_LOAD/DIR_ROL2 3-bit constants;
  - the cmd_op enum (OP_LOAD, OP_SHR, OP_ROL2, OP_LOAD_SHR);
  - the FSM state enum;
  - DATA_W and CNT_W defaults.
- No sub-module; the FSM and step counter fit in one module.
- The bench instantiates shift_reg2 behind this block.

Test Plan:
- LOAD 0xA5 -> one sr_enable cycle with direction 011 and sr_data_in 0xA5; rsp_data=0xA5; rsp_valid 3 cycles after acceptance.
- LOAD_SHR 0xA5, count 3 -> 1 LOAD cycle then 3 cycles of direction 000; rsp_data=0x14; rsp_valid 6 cycles after acceptance.
- After loading 0x81, ROL2 count 1 -> one enable cycle with direction 100; rsp_data=0x06. ROL2 count 4 from 0x81 -> 0x81.
- SHR count 0 with register holding 0x3C -> no sr_enable pulse; rsp_data=0x3C; rsp_valid 2 cycles after acceptance.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, cmd_valid ignored. After rsp_ready, a new command is accepted one cycle later.
- Reset asserted during the 2nd STEP cycle of SHR count 5 -> next cycle sr_enable=0, cmd_ready=1, rsp_valid=0, and no response is ever issued.
